// File: rtl/sram_port_arbiter_if.sv
// Request, response and SRAM signals shared by the port arbiter.
// slave is the arbiter view; master is the view of the IF/MEM stages and the SRAM.
interface sram_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_wen, d_addr, d_wdata,
    input  sram_rdata,
    output i_done, i_rdata,
    output d_done, d_rdata,
    output stallreq_if, stallreq_mem,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_wen, d_addr, d_wdata,
    output sram_rdata,
    input  i_done, i_rdata,
    input  d_done, d_rdata,
    input  stallreq_if, stallreq_mem,
    input  sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares the single-ported data SRAM between fetch (I) and load/store (D).
// One fixed-latency transaction at a time; D wins ties unless I is starved.
module sram_port_arbiter #(
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  sram_port_arbiter_if.slave bus
);

  localparam logic [2:0] LAT = 3'(LATENCY);
  localparam logic [3:0] SL  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        own_i_q, own_i_d;
  logic        wr_q, wr_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        en_q, en_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        any_req;
  logic        grant_i;
  logic [31:0] cap;

  assign any_req = bus.i_req | bus.d_req;
  assign grant_i = bus.i_req &
                   (~bus.d_req | (starve_q == SL));
  assign cap     = wr_q ? 32'h0 : bus.sram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      own_i_q   <= 1'b0;
      wr_q      <= 1'b0;
      wcnt_q    <= 3'd0;
      starve_q  <= 4'd0;
      en_q      <= 1'b0;
      wen_q     <= 4'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      own_i_q   <= own_i_d;
      wr_q      <= wr_d;
      wcnt_q    <= wcnt_d;
      starve_q  <= starve_d;
      en_q      <= en_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // SRAM drive registers are loaded on the edge that enters ISSUE.
  always_comb begin
    state_d   = state_q;
    own_i_d   = own_i_q;
    wr_d      = wr_q;
    wcnt_d    = wcnt_q;
    starve_d  = starve_q;
    en_d      = 1'b0;
    wen_d     = 4'd0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          own_i_d = grant_i;
          en_d    = 1'b1;
          if (grant_i) begin
            wr_d     = 1'b0;
            wen_d    = 4'd0;
            addr_d   = bus.i_addr;
            wdata_d  = 32'h0;
            starve_d = 4'd0;
          end else begin
            wr_d    = |bus.d_wen;
            wen_d   = bus.d_wen;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            if (bus.i_req && starve_q != SL)
              starve_d = starve_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wcnt_d  = LAT;
      end
      WAIT: begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) begin
          state_d = RESP;
          if (own_i_q) begin
            i_rdata_d = cap;
            i_done_d  = 1'b1;
          end else begin
            d_rdata_d = cap;
            d_done_d  = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sram_en      = en_q;
  assign bus.sram_wen     = wen_q;
  assign bus.sram_addr    = addr_q;
  assign bus.sram_wdata   = wdata_q;
  assign bus.i_done       = i_done_q;
  assign bus.d_done       = d_done_q;
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.stallreq_if  = bus.i_req & ~i_done_q;
  assign bus.stallreq_mem = bus.d_req & ~d_done_q;

endmodule
